// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM whose control outputs are registered from the next state,
// plus a saturating retired-instruction counter and an absorbing HALT for illegal encodings.
module mips_mc_controller #(
    parameter logic [15:0] CNT_INIT = 16'h0000  // counter value loaded at reset (preload hook)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Function,
    input  logic        Zero,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        PCSel,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUCtrl,
    output logic [3:0]  state,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic [15:0] cnt_q, cnt_d;
    logic        halted_q, halted_d;
    logic        iord_q, iord_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        ir_write_q, ir_write_d;
    logic        alu_src_a_q, alu_src_a_d;
    logic        reg_write_q, reg_write_d;
    logic        reg_dst_q, reg_dst_d;
    logic        pc_write_q, pc_write_d;
    logic        pc_cond_q, pc_cond_d;
    logic [1:0]  pc_source_q, pc_source_d;
    logic [1:0]  alu_src_b_q, alu_src_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [3:0]  alu_fn;
    logic        fn_ok;

    always_comb begin
        alu_fn = 4'b0010;
        fn_ok  = 1'b1;
        case (Function)
            6'h20:   alu_fn = 4'b0010;
            6'h22:   alu_fn = 4'b0110;
            6'h24:   alu_fn = 4'b0000;
            6'h25:   alu_fn = 4'b0001;
            6'h27:   alu_fn = 4'b0011;
            default: fn_ok  = 1'b0;
        endcase

        // The first edge after reset release enters a real FETCH rather than advancing
        state_d = state_q;
        run_d   = 1'b1;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (Op)
                        6'h23, 6'h2B: state_d = S_MEMADR;
                        6'h00:        state_d = S_EXEC;
                        6'h04:        state_d = S_BRANCH;
                        6'h02:        state_d = S_JUMP;
                        6'h08:        state_d = S_ADDIEX;
                        default:      state_d = S_HALT;
                    endcase
                end
                S_MEMADR: state_d = (Op == 6'h23) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = S_MEMWB;
                S_MEMWB:  state_d = S_FETCH;
                S_MEMWR:  state_d = S_FETCH;
                S_EXEC:   state_d = fn_ok ? S_RWB : S_HALT;
                S_RWB:    state_d = S_FETCH;
                S_BRANCH: state_d = S_FETCH;
                S_JUMP:   state_d = S_FETCH;
                S_ADDIEX: state_d = S_ADDIWB;
                S_ADDIWB: state_d = S_FETCH;
                S_HALT:   state_d = S_HALT;
                default:  state_d = S_HALT;
            endcase
        end

        iord_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        ir_write_d   = 1'b0;
        alu_src_a_d  = 1'b0;
        reg_write_d  = 1'b0;
        reg_dst_d    = 1'b0;
        pc_write_d   = 1'b0;
        pc_cond_d    = 1'b0;
        pc_source_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        alu_ctrl_d   = 4'b0010;
        case (state_d)
            S_FETCH: begin
                mem_read_d  = 1'b1;
                ir_write_d  = 1'b1;
                pc_write_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            S_DECODE: alu_src_b_d = 2'b11;
            S_MEMADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEMRD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                mem_read_d   = 1'b1;
                iord_d       = 1'b1;
            end
            S_MEMWR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_d = 1'b1;
                alu_ctrl_d  = alu_fn;
            end
            S_RWB: begin
                alu_src_a_d = 1'b1;
                alu_ctrl_d  = alu_fn;
                reg_write_d = 1'b1;
                reg_dst_d   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_d = 1'b1;
                alu_ctrl_d  = 4'b0110;
                pc_source_d = 2'b01;
                pc_cond_d   = 1'b1;
            end
            S_JUMP: begin
                pc_source_d = 2'b10;
                pc_write_d  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_ADDIWB: reg_write_d = 1'b1;
            default: ;
        endcase

        halted_d = (state_d == S_HALT);

        cnt_d = cnt_q;
        if (run_q && state_d == S_FETCH && state_q != S_FETCH && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            run_q        <= 1'b0;
            cnt_q        <= CNT_INIT;
            halted_q     <= 1'b0;
            iord_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            ir_write_q   <= 1'b0;
            alu_src_a_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            pc_write_q   <= 1'b0;
            pc_cond_q    <= 1'b0;
            pc_source_q  <= 2'b00;
            alu_src_b_q  <= 2'b00;
            alu_ctrl_q   <= 4'b0000;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            cnt_q        <= cnt_d;
            halted_q     <= halted_d;
            iord_q       <= iord_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            ir_write_q   <= ir_write_d;
            alu_src_a_q  <= alu_src_a_d;
            reg_write_q  <= reg_write_d;
            reg_dst_q    <= reg_dst_d;
            pc_write_q   <= pc_write_d;
            pc_cond_q    <= pc_cond_d;
            pc_source_q  <= pc_source_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
        end
    end

    assign IorD        = iord_q;
    assign MemRead     = mem_read_q;
    assign MemWrite    = mem_write_q;
    assign MemToReg    = mem_to_reg_q;
    assign IRWrite     = ir_write_q;
    assign ALUSrcA     = alu_src_a_q;
    assign RegWrite    = reg_write_q;
    assign RegDst      = reg_dst_q;
    // Branch decision uses the live Zero flag; every other PC load is unconditional
    assign PCSel       = pc_write_q | (pc_cond_q & Zero);
    assign PCSource    = pc_source_q;
    assign ALUSrcB     = alu_src_b_q;
    assign ALUCtrl     = alu_ctrl_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for the multicycle controller: per-cycle state/control checks for each
// instruction class, illegal-opcode halt, asynchronous reset abort and counter saturation.
module tb_mips_mc_controller;

    logic        clk = 1'b0;
    logic        reset, rst2_n;
    logic [5:0]  Op, Function;
    logic        Zero;
    logic        IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSel;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUCtrl, state;
    logic        halted;
    logic [15:0] instr_count;

    logic        IorD2, MemRead2, MemWrite2, MemToReg2, IRWrite2, ALUSrcA2, RegWrite2, RegDst2, PCSel2;
    logic [1:0]  PCSource2, ALUSrcB2;
    logic [3:0]  ALUCtrl2, state2;
    logic        halted2;
    logic [15:0] instr_count2;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .PCSel(PCSel), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
        .state(state), .halted(halted), .instr_count(instr_count)
    );

    // Second instance preloaded near saturation, running a stream of jumps
    mips_mc_controller #(.CNT_INIT(16'hFFFE)) dut_sat (
        .clk(clk), .reset(rst2_n), .Op(6'h02), .Function(6'h00), .Zero(1'b0),
        .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2), .MemToReg(MemToReg2),
        .IRWrite(IRWrite2), .ALUSrcA(ALUSrcA2), .RegWrite(RegWrite2), .RegDst(RegDst2),
        .PCSel(PCSel2), .PCSource(PCSource2), .ALUSrcB(ALUSrcB2), .ALUCtrl(ALUCtrl2),
        .state(state2), .halted(halted2), .instr_count(instr_count2)
    );

    logic [16:0] ctrl, ctrl2;
    assign ctrl  = {IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSel,
                    PCSource, ALUSrcB, ALUCtrl};
    assign ctrl2 = {IorD2, MemRead2, MemWrite2, MemToReg2, IRWrite2, ALUSrcA2, RegWrite2, RegDst2,
                    PCSel2, PCSource2, ALUSrcB2, ALUCtrl2};

    function automatic logic [16:0] cv(input logic iord, mr, mw, m2r, irw, sa, rw, rd, pcs,
                                       input logic [1:0] psrc, sb, input logic [3:0] alu);
        return {iord, mr, mw, m2r, irw, sa, rw, rd, pcs, psrc, sb, alu};
    endfunction

    // Hand-derived control words per state
    localparam logic [16:0] C_F   = 17'b0_1_0_0_1_0_0_0_1_00_01_0010;
    localparam logic [16:0] C_D   = 17'b0_0_0_0_0_0_0_0_0_00_11_0010;
    localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_1_0_0_0_00_10_0010;
    localparam logic [16:0] C_MR  = 17'b1_1_0_0_0_0_0_0_0_00_00_0010;
    localparam logic [16:0] C_MWB = 17'b1_1_0_1_0_0_1_0_0_00_00_0010;
    localparam logic [16:0] C_MW  = 17'b1_0_1_0_0_0_0_0_0_00_00_0010;
    localparam logic [16:0] C_BR1 = 17'b0_0_0_0_0_1_0_0_1_01_00_0110;
    localparam logic [16:0] C_BR0 = 17'b0_0_0_0_0_1_0_0_0_01_00_0110;
    localparam logic [16:0] C_J   = 17'b0_0_0_0_0_0_0_0_1_10_00_0010;
    localparam logic [16:0] C_AIE = 17'b0_0_0_0_0_1_0_0_0_00_10_0010;
    localparam logic [16:0] C_AIW = 17'b0_0_0_0_0_0_1_0_0_00_00_0010;
    localparam logic [16:0] C_H   = 17'b0_0_0_0_0_0_0_0_0_00_00_0010;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
        step();
        chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
        chk({tag, ".ctrl"}, {15'd0, ctrl}, {15'd0, c});
    endtask

    task automatic retire(input string tag);
        exp_cnt++;
        chk({tag, ".count"}, {16'd0, instr_count}, exp_cnt);
        $display("instr %s retired count=%0d", tag, instr_count);
    endtask

    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
    logic [3:0] al_tab [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011};

    initial begin
        reset = 1'b1; rst2_n = 1'b0; Op = 6'h00; Function = 6'h20; Zero = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst.state", {28'd0, state}, 32'd0);
        chk("rst.ctrl", {15'd0, ctrl}, 32'd0);
        chk("rst.count", {16'd0, instr_count}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
        cyc("fetch0", 4'd0, C_F);
        chk("fetch0.count", {16'd0, instr_count}, 32'd0);

        Op = 6'h23;
        cyc("lw.d", 4'd1, C_D); cyc("lw.ma", 4'd2, C_MA); cyc("lw.mr", 4'd3, C_MR);
        cyc("lw.wb", 4'd4, C_MWB); cyc("lw.f", 4'd0, C_F);
        retire("lw");

        Op = 6'h2B;
        cyc("sw.d", 4'd1, C_D); cyc("sw.ma", 4'd2, C_MA); cyc("sw.mw", 4'd5, C_MW);
        cyc("sw.f", 4'd0, C_F);
        retire("sw");

        for (int i = 0; i < 5; i++) begin
            Op = 6'h00; Function = fn_tab[i];
            cyc("r.d", 4'd1, C_D);
            cyc("r.ex", 4'd6, cv(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, al_tab[i]));
            cyc("r.wb", 4'd7, cv(0, 0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, al_tab[i]));
            cyc("r.f", 4'd0, C_F);
            retire("rtype");
        end

        Op = 6'h08;
        cyc("addi.d", 4'd1, C_D); cyc("addi.ex", 4'd10, C_AIE); cyc("addi.wb", 4'd11, C_AIW);
        cyc("addi.f", 4'd0, C_F);
        retire("addi");

        Op = 6'h04; Zero = 1'b1;
        cyc("beq1.d", 4'd1, C_D); cyc("beq1.br", 4'd8, C_BR1); cyc("beq1.f", 4'd0, C_F);
        retire("beq_taken");
        Zero = 1'b0;
        cyc("beq0.d", 4'd1, C_D); cyc("beq0.br", 4'd8, C_BR0); cyc("beq0.f", 4'd0, C_F);
        retire("beq_not");

        Op = 6'h02;
        cyc("j.d", 4'd1, C_D); cyc("j.j", 4'd9, C_J); cyc("j.f", 4'd0, C_F);
        retire("j");

        // Asynchronous reset between edges while in MEMWR
        Op = 6'h2B;
        cyc("abort.d", 4'd1, C_D); cyc("abort.ma", 4'd2, C_MA); cyc("abort.mw", 4'd5, C_MW);
        #2 reset = 1'b0;
        #1;
        chk("abort.ctrl", {15'd0, ctrl}, 32'd0);
        chk("abort.state", {28'd0, state}, 32'd0);
        chk("abort.count", {16'd0, instr_count}, 32'd0);
        step();
        chk("abort.hold", {15'd0, ctrl}, 32'd0);
        reset = 1'b1;
        exp_cnt = 0;
        cyc("abort.f", 4'd0, C_F);
        chk("abort.fcount", {16'd0, instr_count}, 32'd0);
        $display("instr sw aborted by reset count=%0d", instr_count);

        // Illegal opcode: absorbing halt
        Op = 6'h3F;
        cyc("ill.d", 4'd1, C_D);
        cyc("ill.h", 4'd12, C_H);
        chk("ill.halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            cyc("ill.hold", 4'd12, C_H);
            chk("ill.hhalted", {31'd0, halted}, 32'd1);
        end
        chk("ill.count", {16'd0, instr_count}, 32'd0);
        $display("instr illegal_op halted=%0d count=%0d", halted, instr_count);

        // Illegal function code halts out of EXEC
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        cyc("illfn.f", 4'd0, C_F);
        Op = 6'h00; Function = 6'h3F;
        cyc("illfn.d", 4'd1, C_D);
        step();
        chk("illfn.ex", {28'd0, state}, 32'd6);
        step();
        chk("illfn.h", {28'd0, state}, 32'd12);
        chk("illfn.halted", {31'd0, halted}, 32'd1);
        $display("instr illegal_funct halted=%0d", halted);

        // Saturation: preload 0xFFFE, retire three jumps
        rst2_n = 1'b1;
        step();
        chk("sat.f0", {16'd0, instr_count2}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            step(); step();
            chk("sat.jctrl", {15'd0, ctrl2}, {15'd0, C_J});
            step();
            chk("sat.state", {28'd0, state2}, 32'd0);
            chk("sat.count", {16'd0, instr_count2}, 32'h0000FFFF);
            chk("sat.halted", {31'd0, halted2}, 32'd0);
            $display("instr sat_j%0d count=%h", i, instr_count2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have inputs: Op  6  instruction opcode; Function  6  R-type funct; Zero  1  ALU result == 0.
REQ-004 SHALL have 1-bit outputs: IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSel (PC load enable).
REQ-005 SHALL have outputs: PCSource  2  (00 ALUResult, 01 ALUOut, 10 jump target); ALUSrcB  2  (00 B, 01 const 4, 10 sext imm, 11 sext imm<<2).
REQ-006 SHALL have output: ALUCtrl  4  (0000 AND, 0001 OR, 0010 ADD, 0011 NOR, 0110 SUB).
REQ-007 SHALL have outputs: state  4  current state code; halted  1  illegal-instruction stop; instr_count  16  retired instructions.

Function
REQ-008 SHALL be a Moore FSM; all outputs SHALL be decoded from registered state (PCSel additionally ANDed with Zero in BRANCH), with no other input-to-output paths.
REQ-009 SHALL implement states/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, HALT 12.
REQ-010 SHALL deassert every output not listed for a state; in every state, unlisted multi-bit selects SHALL be 0, except ALUCtrl, which SHALL be 0010 when not listed.
REQ-011 FETCH SHALL assert: MemRead, IRWrite, PCSel, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=0010, PCSource=00; next state = DECODE.
REQ-012 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11, ALUCtrl=0010 (branch target into ALUOut).
REQ-013 DECODE next state SHALL be selected by Op: 0x23/0x2B -> MEMADR; 0x00 -> EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDIEX; any other Op -> HALT.
REQ-014 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10, ALUCtrl=0010; next state = MEMRD if Op=0x23, else MEMWR.
REQ-015 MEMRD SHALL assert MemRead, IorD; next state = MEMWB.
REQ-016 MEMWB SHALL assert RegWrite, MemToReg, RegDst=0, and SHALL hold MemRead=1 and IorD=1 so the MDR stays stable; next state = FETCH.
REQ-017 MEMWR SHALL assert MemWrite, IorD; next state = FETCH.
REQ-018 EXEC SHALL assert ALUSrcA=1, ALUSrcB=00, with ALUCtrl mapped from Function: 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x27 -> 0011; any other Function -> next state HALT, else RWB.
REQ-019 RWB SHALL hold the EXEC ALU selects and ALUCtrl, and SHALL assert RegWrite, RegDst=1, MemToReg=0; next state = FETCH.
REQ-020 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUCtrl=0110, PCSource=01, PCSel=Zero; next state = FETCH.
REQ-021 JUMP SHALL assert PCSource=10, PCSel=1; next state = FETCH.
REQ-022 ADDIEX SHALL assert ALUSrcA=1, ALUSrcB=10, ALUCtrl=0010; next state = ADDIWB.
REQ-023 ADDIWB SHALL assert RegWrite, RegDst=0, MemToReg=0; next state = FETCH.
REQ-024 HALT SHALL be absorbing until reset; halted=1; all enables SHALL be 0.
REQ-025 Instruction latency in cycles, FETCH through last state inclusive, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-026 instr_count SHALL increment by 1 on each transition into FETCH from any state other than FETCH, and SHALL saturate at 0xFFFF (no wrap).
REQ-027 An unused state encoding (13-15) SHALL transition to HALT on the next edge.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for clk, force state=FETCH, instr_count=0, and halted=0, and SHALL force all outputs to 0.
REQ-029 Reset asserted mid-instruction (e.g. in MEMWR) SHALL abort the instruction with no further MemWrite or RegWrite.
REQ-030 The first rising edge with reset=1 SHALL be the first FETCH cycle, asserting PCSel and IRWrite.

Verification
REQ-031 Op=0x23 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4; instr_count +1.
REQ-032 Op=0x00, Function=0x22 -> sequence 0,1,6,7,0; ALUCtrl=0110 in states 6 and 7; RegDst=1 in state 7.
REQ-033 Op=0x04 with Zero=1 -> PCSel=1 and PCSource=01 in BRANCH; with Zero=0 -> PCSel=0; both cases return to FETCH after 3 cycles.
REQ-034 Op=0x3F -> DECODE then HALT; halted=1 and all enables=0 for 20 cycles; instr_count unchanged.
REQ-035 reset=0 pulsed asynchronously between edges while in MEMWR -> outputs 0 immediately; after release, state=0 and instr_count=0.
REQ-036 Preload instr_count to 0xFFFE via 2^16-2 j instructions, then 3 more -> instr_count=0xFFFF and holds.
